// File: rtl/cv32e40p_obi_pkg.sv
// Shared types for the OBI credit controller.
// obi_resp_t is one buffered response entry: read data, bus error flag and
// the read/write type of the transaction that produced it.
package cv32e40p_obi_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } obi_resp_t;

  localparam int unsigned OBI_RESP_W = $bits(obi_resp_t);

endpackage

// File: rtl/cv32e40p_obi_sync_fifo.sv
// Synchronous FIFO with combinational head read.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (pointers/count only)
//   push, wdata   - write request and data
//   pop           - remove head entry (ignored when empty)
//   rdata         - head entry
//   full, empty   - occupancy flags
module cv32e40p_obi_sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/cv32e40p_obi_credit_ctrl.sv
// Credit-limited transaction issuer in front of the OBI adapter.
// Requests pass combinationally to trans_* while fewer than MAX_OUTSTANDING
// transactions are issued-but-unconsumed. Each issued transaction's we bit
// is queued in a tag FIFO; each adapter response pops a tag and is stored
// with it in a response FIFO that the consumer drains with rsp_ready_i.
// Ports:
//   req_*      - upstream request handshake and payload
//   trans_*    - request side of the OBI adapter (atop tied to 0)
//   resp_*     - adapter response, always accepted
//   rsp_*      - buffered response to the consumer, rsp_we_o = originating type
//   outstanding_o / busy_o - credit count and nonzero flag
//   spurious_o - registered pulse for a response with no tracked transaction
module cv32e40p_obi_credit_ctrl
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_addr_i,
  input  logic             req_we_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [3:0]       req_be_i,
  output logic             trans_valid_o,
  input  logic             trans_ready_i,
  output logic [31:0]      trans_addr_o,
  output logic             trans_we_o,
  output logic [31:0]      trans_wdata_o,
  output logic [3:0]       trans_be_o,
  output logic [5:0]       trans_atop_o,
  input  logic             resp_valid_i,
  input  logic [31:0]      resp_rdata_i,
  input  logic             resp_err_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             rsp_we_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             busy_o,
  output logic             spurious_o
);

  logic [CNT_W-1:0] cnt;
  logic             can_issue;
  logic             fire;
  logic             pop;
  logic             resp_accept;
  logic             tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic             rsp_full;
  logic             rsp_empty;
  obi_resp_t        rsp_in;
  obi_resp_t        rsp_head;

  // Issue path: purely combinational, credit consumed at the edge.
  assign can_issue     = (cnt < CNT_W'(MAX_OUTSTANDING));
  assign trans_valid_o = req_valid_i & can_issue;
  assign req_ready_o   = trans_ready_i & can_issue;
  assign fire          = trans_valid_o & trans_ready_i;
  assign trans_addr_o  = req_addr_i;
  assign trans_we_o    = req_we_i;
  assign trans_wdata_o = req_wdata_i;
  assign trans_be_o    = req_be_i;
  assign trans_atop_o  = '0;

  // A response only counts if a tag is waiting; otherwise it is dropped.
  assign resp_accept = resp_valid_i & ~tag_empty;

  cv32e40p_obi_sync_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .wdata (req_we_i),
    .pop   (resp_accept),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign rsp_in = '{rdata: resp_rdata_i, err: resp_err_i, we: tag_head};

  cv32e40p_obi_sync_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (OBI_RESP_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_accept),
    .wdata (rsp_in),
    .pop   (pop),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  assign rsp_valid_o   = ~rsp_empty;
  assign pop           = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o   = rsp_head.rdata;
  assign rsp_err_o     = rsp_head.err;
  assign rsp_we_o      = rsp_head.we;
  assign outstanding_o = cnt;
  assign busy_o        = (cnt != '0);

  // Credit counter spans in-flight plus buffered transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      spurious_o <= 1'b0;
    end else begin
      case ({fire, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      spurious_o <= resp_valid_i & tag_empty;
    end
  end

  // Tag entries plus buffered entries equal cnt, so neither FIFO can overflow.
  a_tag_room: assert property (@(posedge clk) disable iff (rst) !(fire && tag_full));
  a_rsp_room: assert property (@(posedge clk) disable iff (rst) !(resp_accept && rsp_full && !pop));

endmodule
